// File: rtl/snake_pkg.sv
// Shared geometry, tile codes and host FSM state type for the snake/VGA tile slice.
package snake_pkg;

  localparam int unsigned TILE_SHIFT = 4;
  localparam int unsigned GRID_W     = 40;
  localparam int unsigned GRID_H     = 30;
  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned DATA_W     = 4;
  localparam int unsigned NUM_TILES  = GRID_W * GRID_H;

  localparam logic [DATA_W-1:0] TILE_EMPTY = DATA_W'(0);
  localparam logic [DATA_W-1:0] TILE_SNAKE = DATA_W'(1);
  localparam logic [DATA_W-1:0] TILE_HEAD  = DATA_W'(2);
  localparam logic [DATA_W-1:0] TILE_FOOD  = DATA_W'(3);
  localparam logic [DATA_W-1:0] TILE_WALL  = DATA_W'(4);

  typedef enum logic [0:0] {
    HIdle,
    HRdWait
  } host_state_e;

endpackage

// File: rtl/tile_ram_arbiter_if.sv
// Host request channel and single-port tile RAM channel of the arbiter.
interface tile_ram_arbiter_if #(
  parameter int unsigned ADDR_W = snake_pkg::ADDR_W,
  parameter int unsigned DATA_W = snake_pkg::DATA_W
);
  logic              iHost_Req;
  logic              iHost_We;
  logic [ADDR_W-1:0] iHost_Addr;
  logic [DATA_W-1:0] iHost_Wdata;
  logic              oHost_Ack;
  logic [DATA_W-1:0] oHost_Rdata;
  logic              oHost_Rvalid;
  logic [ADDR_W-1:0] oRam_Addr;
  logic              oRam_We;
  logic [DATA_W-1:0] oRam_Wdata;
  logic [DATA_W-1:0] iRam_Rdata;

  // Arbiter side: serves the host, drives the RAM.
  modport slave (
    input  iHost_Req, iHost_We, iHost_Addr, iHost_Wdata, iRam_Rdata,
    output oHost_Ack, oHost_Rdata, oHost_Rvalid, oRam_Addr, oRam_We, oRam_Wdata
  );

  // Environment side: host requester plus RAM model.
  modport master (
    output iHost_Req, iHost_We, iHost_Addr, iHost_Wdata, iRam_Rdata,
    input  oHost_Ack, oHost_Rdata, oHost_Rvalid, oRam_Addr, oRam_We, oRam_Wdata
  );
endinterface

// File: rtl/tile_addr_calc.sv
// Combinational tile address: row * GRID_W + col, with a check against the grid size.
module tile_addr_calc #(
  parameter int unsigned GRID_W = 40,
  parameter int unsigned GRID_H = 30,
  parameter int unsigned ADDR_W = 11
) (
  input  logic [ADDR_W-1:0] row_i,
  input  logic [ADDR_W-1:0] col_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              in_range_o
);
  import snake_pkg::*;

  localparam int unsigned NumTiles = GRID_W * GRID_H;

  logic [ADDR_W-1:0] row_base;

  // Linear address; the 40-wide grid uses shift-add instead of a multiplier.
  always_comb begin
    if (GRID_W == 40) begin
      row_base = (row_i << 5) + (row_i << 3);
    end else begin
      row_base = row_i * ADDR_W'(GRID_W);
    end
    addr_o     = row_base + col_i;
    in_range_o = (32'(addr_o) < NumTiles);
  end

endmodule

// File: rtl/tile_ram_arbiter.sv
// Shares the single-port tile RAM between VGA tile fetch (always wins) and game host access.
module tile_ram_arbiter #(
  parameter int unsigned TILE_SHIFT      = snake_pkg::TILE_SHIFT,
  parameter int unsigned GRID_W          = snake_pkg::GRID_W,
  parameter int unsigned GRID_H          = snake_pkg::GRID_H,
  parameter int unsigned ADDR_W          = snake_pkg::ADDR_W,
  parameter int unsigned DATA_W          = snake_pkg::DATA_W,
  parameter bit          HOST_BLANK_ONLY = 1'b1
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic                iVGA_Active,
  input  logic                iV_Blank,
  input  logic [9:0]          iCoord_X,
  input  logic [9:0]          iCoord_Y,
  output logic [DATA_W-1:0]   oTile,
  output logic                oTile_Valid,
  output logic                oFrame_Start,
  tile_ram_arbiter_if.slave   bus
);
  import snake_pkg::*;

  logic              vga_slot;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_in_range;
  logic [ADDR_W-1:0] host_addr;
  logic              host_in_range;
  logic              host_grant;
  logic [DATA_W-1:0] host_rd_data;

  host_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ack_q, ack_d;
  logic              rd_tag_q, rd_tag_d;
  logic              host_oor_q, host_oor_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        vga_tag_q, vga_tag_d;
  logic [1:0]        vga_oor_q, vga_oor_d;
  logic [DATA_W-1:0] tile_q, tile_d;
  logic              tile_valid_q, tile_valid_d;
  logic              vblank_q;

  assign vga_slot = iVGA_Active && (iCoord_X[TILE_SHIFT-1:0] == '0);

  tile_addr_calc #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .ADDR_W (ADDR_W)
  ) u_vga_addr (
    .row_i      (ADDR_W'(iCoord_Y >> TILE_SHIFT)),
    .col_i      (ADDR_W'(iCoord_X >> TILE_SHIFT)),
    .addr_o     (vga_addr),
    .in_range_o (vga_in_range)
  );

  // Host addresses are already linear; row 0 turns the calculator into a pure range check.
  tile_addr_calc #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .ADDR_W (ADDR_W)
  ) u_host_addr (
    .row_i      ('0),
    .col_i      (bus.iHost_Addr),
    .addr_o     (host_addr),
    .in_range_o (host_in_range)
  );

  // ack_q blocks the cycle in which the host is still seeing the previous ack.
  assign host_grant = (state_q == HIdle) && !ack_q && bus.iHost_Req && !vga_slot &&
                      (!bus.iHost_We || !HOST_BLANK_ONLY || iV_Blank);

  // Read data is passed straight through in its return cycle so Rvalid lands one cycle
  // after the ack; out-of-range reads return zero.
  assign host_rd_data = host_oor_q ? '0 : bus.iRam_Rdata;

  // Next-state for host FSM, RAM port, read tags and tile output.
  always_comb begin
    state_d      = state_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = 1'b0;
    ram_wdata_d  = ram_wdata_q;
    ack_d        = 1'b0;
    rd_tag_d     = 1'b0;
    host_oor_d   = host_oor_q;
    rdata_d      = rd_tag_q ? host_rd_data : rdata_q;
    vga_tag_d    = {vga_tag_q[0], vga_slot};
    vga_oor_d    = {vga_oor_q[0], !vga_in_range};
    tile_d       = tile_q;
    tile_valid_d = vga_tag_q[1];

    if (vga_tag_q[1]) begin
      tile_d = vga_oor_q[1] ? '0 : bus.iRam_Rdata;
    end

    if (vga_slot) begin
      ram_addr_d = vga_addr;
    end

    unique case (state_q)
      HIdle: begin
        if (host_grant) begin
          ram_addr_d = host_addr;
          ram_we_d   = bus.iHost_We && host_in_range;
          ack_d      = 1'b1;
          host_oor_d = !host_in_range;
          if (bus.iHost_We) begin
            ram_wdata_d = bus.iHost_Wdata;
          end else begin
            state_d = HRdWait;
          end
        end
      end
      HRdWait: begin
        rd_tag_d = 1'b1;
        state_d  = HIdle;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= HIdle;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      ack_q        <= 1'b0;
      rd_tag_q     <= 1'b0;
      host_oor_q   <= 1'b0;
      rdata_q      <= '0;
      vga_tag_q    <= '0;
      vga_oor_q    <= '0;
      tile_q       <= '0;
      tile_valid_q <= 1'b0;
      vblank_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      ack_q        <= ack_d;
      rd_tag_q     <= rd_tag_d;
      host_oor_q   <= host_oor_d;
      rdata_q      <= rdata_d;
      vga_tag_q    <= vga_tag_d;
      vga_oor_q    <= vga_oor_d;
      tile_q       <= tile_d;
      tile_valid_q <= tile_valid_d;
      vblank_q     <= iV_Blank;
    end
  end

  assign bus.oRam_Addr    = ram_addr_q;
  assign bus.oRam_We      = ram_we_q;
  assign bus.oRam_Wdata   = ram_wdata_q;
  assign bus.oHost_Ack    = ack_q;
  assign bus.oHost_Rvalid = rd_tag_q;
  assign bus.oHost_Rdata  = rd_tag_q ? host_rd_data : rdata_q;
  assign oTile            = tile_q;
  assign oTile_Valid      = tile_valid_q;
  assign oFrame_Start     = iV_Blank & ~vblank_q;

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Directed bench for tile_ram_arbiter with a latency-1 RAM model.
module tb_tile_ram_arbiter;
  import snake_pkg::*;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       iVGA_Active = 1'b0;
  logic       iV_Blank = 1'b0;
  logic [9:0] iCoord_X = '0;
  logic [9:0] iCoord_Y = '0;
  logic [DATA_W-1:0] oTile;
  logic       oTile_Valid;
  logic       oFrame_Start;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [0:2047];
  logic prev_pend;

  tile_ram_arbiter_if bus ();

  tile_ram_arbiter dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .iVGA_Active  (iVGA_Active),
    .iV_Blank     (iV_Blank),
    .iCoord_X     (iCoord_X),
    .iCoord_Y     (iCoord_Y),
    .oTile        (oTile),
    .oTile_Valid  (oTile_Valid),
    .oFrame_Start (oFrame_Start),
    .bus          (bus)
  );

  always #5 iCLK = ~iCLK;

  // Single-port RAM, read latency 1, old data on read-during-write.
  always @(posedge iCLK) begin
    if (bus.oRam_We) mem[bus.oRam_Addr] <= bus.oRam_Wdata;
    bus.iRam_Rdata <= mem[bus.oRam_Addr];
  end

  // Host must hold its request until the ack is seen.
  always @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      prev_pend <= 1'b0;
    end else begin
      if (prev_pend && !bus.iHost_Req && !bus.oHost_Ack) begin
        errors++;
        $display("FAIL host_req_dropped req=%b ack=%b required req=1", bus.iHost_Req,
                 bus.oHost_Ack);
      end
      prev_pend <= bus.iHost_Req && !bus.oHost_Ack;
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge iCLK);
    checks++;
    if ({oTile, oTile_Valid, oFrame_Start, bus.oHost_Ack, bus.oHost_Rdata, bus.oHost_Rvalid,
         bus.oRam_Addr, bus.oRam_We, bus.oRam_Wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs tile=%h tv=%b fs=%b ack=%b rd=%h rv=%b addr=%h we=%b wd=%h required all 0",
               oTile, oTile_Valid, oFrame_Start, bus.oHost_Ack, bus.oHost_Rdata,
               bus.oHost_Rvalid, bus.oRam_Addr, bus.oRam_We, bus.oRam_Wdata);
    end
    iRST_N = 1'b1;
  endtask

  task automatic test_vga_fetch();
    @(negedge iCLK);
    iVGA_Active = 1'b1; iCoord_X = 10'd80; iCoord_Y = 10'd32;
    @(negedge iCLK);
    checks++;
    if (bus.oRam_Addr !== 11'd85 || bus.oRam_We !== 1'b0) begin
      errors++;
      $display("FAIL vga_addr addr=%0d we=%b required 85/0", bus.oRam_Addr, bus.oRam_We);
    end
    iVGA_Active = 1'b0;
    @(negedge iCLK);
    checks++;
    if (oTile_Valid !== 1'b0) begin
      errors++;
      $display("FAIL vga_early_valid valid=%b required 0", oTile_Valid);
    end
    @(negedge iCLK);
    checks++;
    if (oTile !== 4'd7 || oTile_Valid !== 1'b1) begin
      errors++;
      $display("FAIL vga_tile tile=%0d valid=%b required 7/1", oTile, oTile_Valid);
    end
    @(negedge iCLK);
    checks++;
    if (oTile !== 4'd7 || oTile_Valid !== 1'b0) begin
      errors++;
      $display("FAIL vga_tile_hold tile=%0d valid=%b required 7/0", oTile, oTile_Valid);
    end
  endtask

  task automatic test_conflict();
    @(negedge iCLK);
    iVGA_Active = 1'b1; iCoord_X = 10'd16; iCoord_Y = 10'd0;
    bus.iHost_Req = 1'b1; bus.iHost_We = 1'b0; bus.iHost_Addr = 11'd3;
    @(negedge iCLK);
    checks++;
    if (bus.oRam_Addr !== 11'd1 || bus.oHost_Ack !== 1'b0) begin
      errors++;
      $display("FAIL conflict_vga_first addr=%0d ack=%b required 1/0", bus.oRam_Addr,
               bus.oHost_Ack);
    end
    iCoord_X = 10'd17;
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Ack !== 1'b1 || bus.oRam_Addr !== 11'd3 || bus.oRam_We !== 1'b0) begin
      errors++;
      $display("FAIL conflict_host_ack ack=%b addr=%0d we=%b required 1/3/0", bus.oHost_Ack,
               bus.oRam_Addr, bus.oRam_We);
    end
    bus.iHost_Req = 1'b0; iVGA_Active = 1'b0;
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Rvalid !== 1'b1 || bus.oHost_Rdata !== 4'd9) begin
      errors++;
      $display("FAIL conflict_rdata rvalid=%b rdata=%0d required 1/9", bus.oHost_Rvalid,
               bus.oHost_Rdata);
    end
    checks++;
    if (oTile !== 4'd4 || oTile_Valid !== 1'b1) begin
      errors++;
      $display("FAIL conflict_tile tile=%0d valid=%b required 4/1", oTile, oTile_Valid);
    end
  endtask

  task automatic test_blank_gating();
    int acks;
    @(negedge iCLK);
    iV_Blank = 1'b0;
    bus.iHost_Req = 1'b1; bus.iHost_We = 1'b1; bus.iHost_Addr = 11'd10; bus.iHost_Wdata = 4'd2;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLK);
      if (bus.oHost_Ack === 1'b1) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL blank_no_ack acks=%0d required 0", acks);
    end
    iV_Blank = 1'b1;
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Ack !== 1'b1 || bus.oRam_We !== 1'b1 || bus.oRam_Addr !== 11'd10 ||
        bus.oRam_Wdata !== 4'd2) begin
      errors++;
      $display("FAIL blank_write ack=%b we=%b addr=%0d wd=%0d required 1/1/10/2",
               bus.oHost_Ack, bus.oRam_We, bus.oRam_Addr, bus.oRam_Wdata);
    end
    bus.iHost_Req = 1'b0;
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Ack !== 1'b0 || bus.oRam_We !== 1'b0) begin
      errors++;
      $display("FAIL blank_ack_pulse ack=%b we=%b required 0/0", bus.oHost_Ack, bus.oRam_We);
    end
    bus.iHost_Req = 1'b1; bus.iHost_We = 1'b0; bus.iHost_Addr = 11'd10;
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Ack !== 1'b1) begin
      errors++;
      $display("FAIL blank_read_ack ack=%b required 1", bus.oHost_Ack);
    end
    bus.iHost_Req = 1'b0;
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Rvalid !== 1'b1 || bus.oHost_Rdata !== 4'd2) begin
      errors++;
      $display("FAIL blank_readback rvalid=%b rdata=%0d required 1/2", bus.oHost_Rvalid,
               bus.oHost_Rdata);
    end
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Rvalid !== 1'b0 || bus.oHost_Rdata !== 4'd2) begin
      errors++;
      $display("FAIL rdata_hold rvalid=%b rdata=%0d required 0/2", bus.oHost_Rvalid,
               bus.oHost_Rdata);
    end
  endtask

  task automatic test_out_of_range();
    @(negedge iCLK);
    bus.iHost_Req = 1'b1; bus.iHost_We = 1'b1; bus.iHost_Addr = 11'd1200; bus.iHost_Wdata = 4'd5;
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Ack !== 1'b1 || bus.oRam_We !== 1'b0) begin
      errors++;
      $display("FAIL oor_write ack=%b we=%b required 1/0", bus.oHost_Ack, bus.oRam_We);
    end
    bus.iHost_Req = 1'b0;
    @(negedge iCLK);
    bus.iHost_Req = 1'b1; bus.iHost_We = 1'b0; bus.iHost_Addr = 11'd1200;
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Ack !== 1'b1) begin
      errors++;
      $display("FAIL oor_read_ack ack=%b required 1", bus.oHost_Ack);
    end
    bus.iHost_Req = 1'b0;
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Rvalid !== 1'b1 || bus.oHost_Rdata !== 4'd0) begin
      errors++;
      $display("FAIL oor_read rvalid=%b rdata=%0d required 1/0", bus.oHost_Rvalid,
               bus.oHost_Rdata);
    end
    checks++;
    if (mem[1200] !== 4'd15) begin
      errors++;
      $display("FAIL oor_write_suppressed mem=%0d required 15", mem[1200]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge iCLK);
    bus.iHost_Req = 1'b1; bus.iHost_We = 1'b1; bus.iHost_Addr = 11'd20; bus.iHost_Wdata = 4'd3;
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Ack !== 1'b1 || bus.oRam_Addr !== 11'd20) begin
      errors++;
      $display("FAIL b2b_first ack=%b addr=%0d required 1/20", bus.oHost_Ack, bus.oRam_Addr);
    end
    bus.iHost_Addr = 11'd21; bus.iHost_Wdata = 4'd4;
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap ack=%b required 0", bus.oHost_Ack);
    end
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Ack !== 1'b1 || bus.oRam_Addr !== 11'd21 || bus.oRam_Wdata !== 4'd4) begin
      errors++;
      $display("FAIL b2b_second ack=%b addr=%0d wd=%0d required 1/21/4", bus.oHost_Ack,
               bus.oRam_Addr, bus.oRam_Wdata);
    end
    bus.iHost_Req = 1'b0;
    @(negedge iCLK);
    checks++;
    if (mem[20] !== 4'd3 || mem[21] !== 4'd4) begin
      errors++;
      $display("FAIL b2b_mem m20=%0d m21=%0d required 3/4", mem[20], mem[21]);
    end
  endtask

  task automatic test_frame_tick();
    int pulses;
    @(negedge iCLK);
    iV_Blank = 1'b0;
    repeat (2) @(negedge iCLK);
    iV_Blank = 1'b1;
    #1;
    checks++;
    if (oFrame_Start !== 1'b1) begin
      errors++;
      $display("FAIL frame_pulse fs=%b required 1", oFrame_Start);
    end
    pulses = 0;
    for (int i = 0; i < 45 * 800; i++) begin
      @(negedge iCLK);
      if (oFrame_Start === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL frame_single pulses=%0d required 0", pulses);
    end
    iV_Blank = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    int rv;
    @(negedge iCLK);
    bus.iHost_Req = 1'b1; bus.iHost_We = 1'b0; bus.iHost_Addr = 11'd85;
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Ack !== 1'b1) begin
      errors++;
      $display("FAIL rst_read_ack ack=%b required 1", bus.oHost_Ack);
    end
    iRST_N = 1'b0;
    bus.iHost_Req = 1'b0;
    #1;
    checks++;
    if ({oTile, oTile_Valid, oFrame_Start, bus.oHost_Ack, bus.oHost_Rdata, bus.oHost_Rvalid,
         bus.oRam_Addr, bus.oRam_We, bus.oRam_Wdata} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs tile=%h tv=%b ack=%b rd=%h rv=%b addr=%h we=%b wd=%h required all 0",
               oTile, oTile_Valid, bus.oHost_Ack, bus.oHost_Rdata, bus.oHost_Rvalid,
               bus.oRam_Addr, bus.oRam_We, bus.oRam_Wdata);
    end
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    rv = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      if (bus.oHost_Rvalid !== 1'b0) rv++;
    end
    checks++;
    if (rv !== 0) begin
      errors++;
      $display("FAIL rst_no_rvalid count=%0d required 0", rv);
    end
    bus.iHost_Req = 1'b1; bus.iHost_We = 1'b0; bus.iHost_Addr = 11'd85;
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Ack !== 1'b1) begin
      errors++;
      $display("FAIL rst_reissue_ack ack=%b required 1", bus.oHost_Ack);
    end
    bus.iHost_Req = 1'b0;
    @(negedge iCLK);
    checks++;
    if (bus.oHost_Rvalid !== 1'b1 || bus.oHost_Rdata !== 4'd7) begin
      errors++;
      $display("FAIL rst_reissue_data rvalid=%b rdata=%0d required 1/7", bus.oHost_Rvalid,
               bus.oHost_Rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = TILE_EMPTY;
    mem[85]   = 4'd7;
    mem[1]    = 4'd4;
    mem[3]    = 4'd9;
    mem[1200] = 4'd15;
    bus.iHost_Req   = 1'b0;
    bus.iHost_We    = 1'b0;
    bus.iHost_Addr  = '0;
    bus.iHost_Wdata = '0;
    test_reset();
    test_vga_fetch();
    test_conflict();
    test_blank_gating();
    test_out_of_range();
    test_back_to_back();
    test_frame_tick();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_ram_arbiter.md
Name: tile_ram_arbiter

Overview:
- Arbitrates one single-port tile RAM (40x30 grid of 16x16-pixel tiles on a 640x480 screen) between two requesters: the VGA pixel pipeline (tile fetch) and the game logic (host read/write of snake/food tiles).
- Sits between the VGA timing generator (pixel coordinates, active/blank flags) and the snake game FSM.
- Generates a frame-start tick for the game logic.

Parameters:
- TILE_SHIFT, 4, log2 of tile edge in pixels (tile edge TILE_PX = 16).
- GRID_W, 40, tiles per row.
- GRID_H, 30, tile rows.
- ADDR_W, 11, RAM address width (must satisfy GRID_W*GRID_H <= 2^ADDR_W).
- DATA_W, 4, tile code width.
- HOST_BLANK_ONLY, 1, when 1, host writes are granted only while iV_Blank=1; host reads are never restricted.

Ports:
- iCLK  in  1  pixel clock.
- iRST_N  in  1  asynchronous, active-low reset.
- iVGA_Active  in  1  high when iCoord_X/iCoord_Y are inside the visible area.
- iV_Blank  in  1  high during vertical blanking.
- iCoord_X  in  10  visible pixel column 0..639.
- iCoord_Y  in  10  visible pixel row 0..479.
- oTile  out  DATA_W  tile code for the current tile column.
- oTile_Valid  out  1  oTile updated this cycle.
- iHost_Req  in  1  host request; held until oHost_Ack.
- iHost_We  in  1  1=write, 0=read; stable while iHost_Req=1.
- iHost_Addr  in  ADDR_W  host tile address.
- iHost_Wdata  in  DATA_W  host write data.
- oHost_Ack  out  1  one-cycle pulse: request issued to RAM.
- oHost_Rdata  out  DATA_W  read data; held until the next host read.
- oHost_Rvalid  out  1  one-cycle pulse, 1 cycle after the ack of a read.
- oRam_Addr  out  ADDR_W  RAM address.
- oRam_We  out  1  RAM write enable.
- oRam_Wdata  out  DATA_W  RAM write data.
- iRam_Rdata  in  DATA_W  RAM read data, valid 1 cycle after the address (fixed latency 1).
- oFrame_Start  out  1  one-cycle pulse on the rising edge of iV_Blank.

Behaviour:
- Reset values: all outputs 0. Internal state: host FSM in H_IDLE, read-tag pipeline cleared. Reset mid-operation drops any pending host request; the host must re-request.
- VGA slot: a cycle with iVGA_Active=1 and iCoord_X[TILE_SHIFT-1:0]==0.
  - In a VGA slot, oRam_Addr = (iCoord_Y>>TILE_SHIFT)*GRID_W + (iCoord_X>>TILE_SHIFT). With the defaults, row*40 is computed as (row<<5)+(row<<3), 11-bit unsigned.
  - oRam_We = 0 in a VGA slot.
- All RAM-facing outputs and oTile are registered.
- VGA latency:
  - Address is registered at cycle T+1 for a slot at cycle T.
  - RAM data returns at T+2.
  - oTile/oTile_Valid are registered at T+3 (slot to oTile = 3 cycles).
  - The downstream pixel path delays coordinates by 3 to match.
  - oTile holds its value between fetches.
- Priority: the VGA slot always wins. The host is never granted in a VGA slot, so worst-case host wait during active video is 1 cycle.
- Host FSM:
  - H_IDLE: iHost_Req=1, no VGA slot, and (iHost_We=0 or HOST_BLANK_ONLY=0 or iV_Blank=1) -> issue the RAM op, pulse oHost_Ack.
    - Write -> stay H_IDLE.
    - Read -> H_RDWAIT.
  - H_RDWAIT: capture iRam_Rdata into oHost_Rdata, pulse oHost_Rvalid, go to H_IDLE.
  - Back-to-back host ops: a new ack is possible no earlier than the cycle after H_RDWAIT exits, or the cycle after a write ack.
- Idle cycles: oRam_We=0 and oRam_Addr holds its last value.
- Out-of-range host address (>= GRID_W*GRID_H): acked normally; a write is suppressed (oRam_We=0); a read returns 0.
- Dropping iHost_Req before ack is a protocol violation; bench assertion only, no RTL recovery.
- oFrame_Start: iV_Blank registered once; pulse = iV_Blank & ~iV_Blank_q.

Decomposition:
- Shared package (snake_pkg): TILE_SHIFT, GRID_W, GRID_H, ADDR_W, DATA_W, and tile-code constants (EMPTY=0, SNAKE=1, HEAD=2, FOOD=3, WALL=4).
- Sub-module tile_addr_calc: combinational row*GRID_W+col with range check. Shared by the VGA slot and the host range check.

Test Plan:
- VGA fetch: preload addr 85 = 7. Drive Y=32, X=80, active -> oRam_Addr=85 at T+1; oTile=7, oTile_Valid=1 at T+3.
- Conflict: host read req at addr 3 in the same cycle as a VGA slot (X=16) -> VGA address issued first; oHost_Ack one cycle later; oHost_Rvalid the cycle after the ack with the correct data.
- Blank gating: HOST_BLANK_ONLY=1, write req addr 10 data 2 with iV_Blank=0 -> no ack. Raise iV_Blank -> ack next eligible cycle. A later read of addr 10 returns 2.
- Out of range: write addr 1200 data 5 -> ack pulses, oRam_We stays 0. Read addr 1200 -> Rdata=0.
- Frame tick: iV_Blank 0->1 -> single oFrame_Start pulse. Held high for 45 lines -> no further pulses.
- Reset mid-read: assert iRST_N=0 in H_RDWAIT -> all outputs 0, no Rvalid after release. The request is re-issued and completes normally.
